// File: rtl/rate_uart_reporter.sv
//==============================================================================
// Module      : rate_uart_reporter
// Description : Converts a strobed 16-bit rate value to five ASCII decimal
//               digits (double dabble) and sends them plus CR LF on 8N1 UART.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module rate_uart_reporter #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic [15:0] count,
    input  logic        count_valid,
    output logic        tx,
    output logic        busy,
    output logic        overrun
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] c_BAUD_ONE  = BAUD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_SEND    = 2'd2
    } state_t;

    state_t             r_state_q,   w_state_d;
    logic [15:0]        r_bin_q,     w_bin_d;
    logic [19:0]        r_bcd_q,     w_bcd_d;
    logic [3:0]         r_step_q,    w_step_d;
    logic [BAUD_W-1:0]  r_baud_q,    w_baud_d;
    logic [3:0]         r_bit_q,     w_bit_d;
    logic [2:0]         r_byte_q,    w_byte_d;
    logic               r_tx_q,      w_tx_d;
    logic               r_overrun_q, w_overrun_d;

    logic [15:0]        w_bcd_adj_lo;
    logic [2:0]         w_bcd_adj_hi;
    logic [7:0]         w_char;
    logic [2:0]         w_data_idx;
    logic               w_frame_bit;

    // The top digit never exceeds 6, so only its low three bits survive the shift.
    always_comb begin
        w_bcd_adj_lo = r_bcd_q[15:0];
        for (int i = 0; i < 4; i++) begin
            if (r_bcd_q[4*i +: 4] >= 4'd5) begin
                w_bcd_adj_lo[4*i +: 4] = r_bcd_q[4*i +: 4] + 4'd3;
            end
        end
        w_bcd_adj_hi = r_bcd_q[18:16];
        if (r_bcd_q[19:16] >= 4'd5) begin
            w_bcd_adj_hi = 3'(r_bcd_q[18:16] + 3'd3);
        end
    end

    always_comb begin
        case (r_byte_q)
            3'd0:    w_char = {4'h3, r_bcd_q[19:16]};
            3'd1:    w_char = {4'h3, r_bcd_q[15:12]};
            3'd2:    w_char = {4'h3, r_bcd_q[11:8]};
            3'd3:    w_char = {4'h3, r_bcd_q[7:4]};
            3'd4:    w_char = {4'h3, r_bcd_q[3:0]};
            3'd5:    w_char = 8'h0D;
            default: w_char = 8'h0A;
        endcase
    end

    always_comb begin
        w_data_idx  = 3'(r_bit_q - 4'd1);
        w_frame_bit = 1'b1;
        if (r_bit_q == 4'd0) begin
            w_frame_bit = 1'b0;
        end else if (r_bit_q <= 4'd8) begin
            w_frame_bit = w_char[w_data_idx];
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_bin_d     = r_bin_q;
        w_bcd_d     = r_bcd_q;
        w_step_d    = r_step_q;
        w_baud_d    = r_baud_q;
        w_bit_d     = r_bit_q;
        w_byte_d    = r_byte_q;
        w_tx_d      = r_tx_q;
        w_overrun_d = r_overrun_q | (count_valid && (r_state_q != S_IDLE));

        case (r_state_q)
            S_IDLE: begin
                if (count_valid) begin
                    w_state_d = S_CONVERT;
                    w_bin_d   = count;
                    w_bcd_d   = '0;
                    w_step_d  = '0;
                end
            end
            S_CONVERT: begin
                w_bcd_d  = {w_bcd_adj_hi, w_bcd_adj_lo, r_bin_q[15]};
                w_bin_d  = {r_bin_q[14:0], 1'b0};
                w_step_d = r_step_q + 4'd1;
                if (r_step_q == 4'd15) begin
                    w_state_d = S_SEND;
                    w_byte_d  = '0;
                    w_bit_d   = '0;
                    w_baud_d  = '0;
                end
            end
            S_SEND: begin
                // Bit index 10 marks the final stop bit as fully elapsed.
                if (r_bit_q == 4'd10) begin
                    w_state_d = S_IDLE;
                    w_tx_d    = 1'b1;
                    w_byte_d  = '0;
                    w_bit_d   = '0;
                    w_baud_d  = '0;
                end else begin
                    w_tx_d = w_frame_bit;
                    if (r_baud_q == c_BAUD_LAST) begin
                        w_baud_d = '0;
                        if ((r_bit_q == 4'd9) && (r_byte_q != 3'd6)) begin
                            w_bit_d  = '0;
                            w_byte_d = r_byte_q + 3'd1;
                        end else begin
                            w_bit_d = r_bit_q + 4'd1;
                        end
                    end else begin
                        w_baud_d = r_baud_q + c_BAUD_ONE;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            r_state_q   <= S_IDLE;
            r_bin_q     <= '0;
            r_bcd_q     <= '0;
            r_step_q    <= '0;
            r_baud_q    <= '0;
            r_bit_q     <= '0;
            r_byte_q    <= '0;
            r_tx_q      <= 1'b1;
            r_overrun_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_bin_q     <= w_bin_d;
            r_bcd_q     <= w_bcd_d;
            r_step_q    <= w_step_d;
            r_baud_q    <= w_baud_d;
            r_bit_q     <= w_bit_d;
            r_byte_q    <= w_byte_d;
            r_tx_q      <= w_tx_d;
            r_overrun_q <= w_overrun_d;
        end
    end

    assign tx      = r_tx_q;
    assign busy    = (r_state_q != S_IDLE);
    assign overrun = r_overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_rate_uart_reporter.sv
//==============================================================================
// Module      : tb_rate_uart_reporter
// Description : Self-checking bench for rate_uart_reporter against a
//               timeline-based reference model and a UART frame decoder.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rate_uart_reporter;

    localparam int CPB      = 10;
    localparam int BUSY_LEN = 17 + 70 * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] count;
    logic        count_valid;
    logic        tx, busy, overrun;

    int checks = 0;
    int errors = 0;

    rate_uart_reporter #(.CLK_HZ(1000), .BAUD(100)) dut (
        .clk100      (clk),
        .reset       (reset),
        .count       (count),
        .count_valid (count_valid),
        .tx          (tx),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ASCII report character k (0..6) for value v.
    function automatic logic [7:0] exp_char(input int v, input int k);
        int p;
        if (k == 5) return 8'h0D;
        if (k == 6) return 8'h0A;
        p = 1;
        for (int i = 0; i < 4 - k; i++) p = p * 10;
        return 8'(48 + (v / p) % 10);
    endfunction

    function automatic logic [55:0] exp_str(input int v);
        logic [55:0] s;
        for (int k = 0; k < 7; k++) s[55-8*k -: 8] = exp_char(v, k);
        return s;
    endfunction

    function automatic logic frame_bit(input int v, input int pos);
        int b;
        logic [7:0] ch;
        ch = exp_char(v, pos / (10 * CPB));
        b  = (pos / CPB) % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return ch[b-1];
    endfunction

    // Reference model: outputs are a function of time since the last accepted strobe.
    logic model_en = 1'b0;
    int   cyc      = 0;
    int   m_start  = -1;
    int   m_val    = 0;
    logic m_tx     = 1'b1;
    logic m_busy   = 1'b0;
    logic m_ovr    = 1'b0;

    always @(posedge clk) begin
        int d;
        cyc++;
        if (reset) begin
            m_start = -1;
            m_ovr   = 1'b0;
        end else if (count_valid) begin
            if (m_start >= 0 && (cyc - m_start) <= BUSY_LEN) m_ovr = 1'b1;
            else begin
                m_start = cyc;
                m_val   = int'(count);
            end
        end
        d      = cyc - m_start;
        m_busy = (m_start >= 0) && (d < BUSY_LEN);
        m_tx   = (m_start >= 0 && d >= 17 && d < BUSY_LEN) ? frame_bit(m_val, d - 17) : 1'b1;
    end

    always @(negedge clk) begin
        if (model_en) begin
            chk("cyc_tx", 64'(tx), 64'(m_tx));
            chk("cyc_busy", 64'(busy), 64'(m_busy));
            chk("cyc_overrun", 64'(overrun), 64'(m_ovr));
        end
    end

    int busy_run  = 0;
    int last_busy = 0;
    always @(negedge clk) begin
        if (model_en) begin
            if (busy === 1'b1) busy_run++;
            else if (busy_run != 0) begin
                last_busy = busy_run;
                busy_run  = 0;
            end
        end
    end

    task automatic strobe(input int v);
        count       = 16'(v);
        count_valid = 1'b1;
        @(posedge clk); #1;
        count_valid = 1'b0;
    endtask

    // Called just after the accepting edge; decodes 7 back-to-back frames.
    task automatic receive(output logic [55:0] got, output int lat);
        int cur;
        int tgt;
        logic [7:0] ch;
        got = '0;
        lat = 0;
        ch  = '0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (tx !== 1'b0 && lat < 100);
        if (tx !== 1'b0) begin
            chk("start_timeout", 64'(0), 64'(1));
            return;
        end
        cur = lat;
        for (int j = 0; j < 70; j++) begin
            tgt = lat + j * CPB + CPB / 2;
            while (cur < tgt) begin
                @(posedge clk); #1;
                cur++;
            end
            if (j % 10 == 0) chk("start_bit", 64'(tx), 64'(0));
            else if (j % 10 == 9) begin
                chk("stop_bit", 64'(tx), 64'(1));
                got[55-8*(j/10) -: 8] = ch;
            end else ch[(j % 10) - 1] = tx;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            if (busy === 1'b0) return;
            @(posedge clk); #1;
        end
        chk("idle_timeout", 64'(1), 64'(0));
    endtask

    initial begin
        logic [55:0] got;
        int lat;
        int v;
        int bad;

        reset = 1'b1; count = '0; count_valid = 1'b0;
        @(posedge clk); #1;
        model_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_tx", 64'(tx), 64'(1));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_overrun", 64'(overrun), 64'(0));
        repeat (3) @(posedge clk); #1;

        strobe(1234);
        receive(got, lat);
        chk("latency_1234", 64'(lat), 64'(17));
        chk("bytes_1234", 64'(got), 64'(56'h30313233340D0A));
        wait_idle();
        repeat (2) @(posedge clk); #1;
        chk("busy_len_1234", 64'(last_busy), 64'(717));
        chk("overrun_1234", 64'(overrun), 64'(0));

        strobe(65535);
        receive(got, lat);
        chk("bytes_65535", 64'(got), 64'(56'h36353533350D0A));
        wait_idle();
        repeat (3) @(posedge clk); #1;

        strobe(0);
        receive(got, lat);
        chk("bytes_0", 64'(got), 64'(56'h30303030300D0A));
        wait_idle();
        repeat (3) @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            v = int'($urandom_range(0, 65535));
            strobe(v);
            receive(got, lat);
            chk("latency_rand", 64'(lat), 64'(17));
            chk("bytes_rand", 64'(got), 64'(exp_str(v)));
            wait_idle();
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #1;
        end

        // Drop during SEND, then accept two cycles after busy falls.
        v = int'($urandom_range(0, 65535));
        strobe(v);
        fork
            receive(got, lat);
            begin
                repeat (116) @(posedge clk);
                #1 strobe(42);
            end
        join
        chk("bytes_first_kept", 64'(got), 64'(exp_str(v)));
        chk("overrun_set", 64'(overrun), 64'(1));
        wait_idle();
        @(posedge clk); #1;
        strobe(42);
        receive(got, lat);
        chk("bytes_42", 64'(got), 64'(56'h30303034320D0A));
        chk("overrun_sticky", 64'(overrun), 64'(1));
        wait_idle();
        repeat (3) @(posedge clk); #1;

        // Reset in the middle of byte 2.
        strobe(5555);
        repeat (261) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset_tx", 64'(tx), 64'(1));
        chk("midreset_busy", 64'(busy), 64'(0));
        chk("midreset_overrun", 64'(overrun), 64'(0));
        repeat (5) @(posedge clk); #1;
        strobe(7);
        receive(got, lat);
        chk("bytes_7", 64'(got), 64'(56'h30303030370D0A));
        wait_idle();
        repeat (3) @(posedge clk); #1;

        // Strobe on the very edge that returns to IDLE is dropped.
        strobe(300);
        repeat (716) @(posedge clk);
        #1 count = 16'd999; count_valid = 1'b1;
        @(posedge clk); #1;
        count_valid = 1'b0;
        chk("edge_drop_busy", 64'(busy), 64'(0));
        chk("edge_drop_overrun", 64'(overrun), 64'(1));
        repeat (40) @(posedge clk); #1;
        chk("edge_drop_tx_idle", 64'(tx), 64'(1));

        // Strobe coincident with reset is ignored.
        reset = 1'b1; count = 16'd123; count_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; count_valid = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        chk("reset_strobe_idle", 64'(bad), 64'(0));
        chk("reset_strobe_overrun", 64'(overrun), 64'(0));

        // Random strobes, including many that land while busy.
        repeat (5000) begin
            count       = 16'($urandom);
            count_valid = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        count_valid = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
